adder_issuer: RTL and testbench

- Front-end that drives the existing adder_wrapper ivalid/busy/ovalid interface from the initiator side.
- Accepts operand pairs on a valid/ready stream and buffers them.
- Issues each pair to the adder only when the adder is not busy and result space is guaranteed.
- Collects {Carry,Sum} results into an in-order result stream with backpressure.

---
 rtl/adder_if_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/adder_issuer.sv | 182 ++++++++++++++++++
 tb/tb_adder_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_if_pkg.sv
// Shared types for the adder issuer: issue FSM states, FIFO count width
// helper and the {carry, sum} result payload.
package adder_if_pkg;

    // Default operand width; the result payload below is sized from it.
    localparam int unsigned DWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } issue_state_e;

    // Width of a 0..depth occupancy counter.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Adder return payload, packed as {carry, sum}.
    typedef struct packed {
        logic                  carry;
        logic [DWIDTH_DEF-1:0] sum;
    } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered head (no fall-through), registered flags.
// Ports:
//   clk, rstn     clock, async active-low reset (clears storage too)
//   push, din     write request / data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   dout          current head entry
//   full, empty   registered occupancy flags
//   count         number of stored entries, 0..DEPTH
module sync_fifo
    import adder_if_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_nxt;

    // A pop frees a slot in the same cycle, so push-while-full is allowed then.
    assign w_do_pop  = pop && !r_empty;
    assign w_do_push = push && (!r_full || w_do_pop);

    // Next occupancy.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/adder_issuer.sv
// Initiator-side front end for the adder_wrapper ivalid/busy/ovalid port.
// Buffers operand pairs, issues one pair at a time when the adder is idle
// and result space is reserved, and returns {carry,sum} in request order.
// Ports:
//   clk, rstn                   clock, async active-low reset
//   s_valid/s_ready/s_a/s_b     operand request stream (s_ready registered)
//   a_in1/a_in2/a_ivalid        issue side towards the adder (registered)
//   a_busy/a_sum/a_carry/a_ovalid  adder status and return
//   m_valid/m_ready/m_sum       in-order result stream
//   inflight                    issued but not yet returned requests
//   err_spurious                sticky flag for ovalid with nothing in flight
module adder_issuer
    import adder_if_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DWIDTH-1:0]       s_a,
    input  logic [DWIDTH-1:0]       s_b,
    output logic [DWIDTH-1:0]       a_in1,
    output logic [DWIDTH-1:0]       a_in2,
    output logic                    a_ivalid,
    input  logic                    a_busy,
    input  logic [DWIDTH-1:0]       a_sum,
    input  logic                    a_carry,
    input  logic                    a_ovalid,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DWIDTH:0]         m_sum,
    output logic [cnt_w(DEPTH)-1:0] inflight,
    output logic                    err_spurious
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned UW = CW + 1;
    localparam int unsigned QW = 2 * DWIDTH;
    localparam int unsigned RW = DWIDTH + 1;

    issue_state_e      r_state;
    logic              r_s_ready;
    logic              r_a_ivalid;
    logic [DWIDTH-1:0] r_a_in1;
    logic [DWIDTH-1:0] r_a_in2;
    logic [CW-1:0]     r_inflight;
    logic              r_err;

    logic [QW-1:0]     w_req_head;
    logic              w_req_full;
    logic              w_req_empty;
    logic [CW-1:0]     w_req_count;
    logic              w_req_push;
    logic [UW-1:0]     w_req_cnt_nxt;

    logic [RW-1:0]     w_res_head;
    logic              w_res_full;
    logic              w_res_empty;
    logic [CW-1:0]     w_res_count;
    logic              w_res_push;
    logic              w_res_pop;
    result_t           w_ret;

    logic [UW-1:0]     w_used;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_ret_ok;
    logic              w_spur;

    // Request side: accept only against the registered ready.
    assign w_req_push = s_valid && r_s_ready && !w_req_full;

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_req_push),
        .pop   (w_issue),
        .din   ({s_a, s_b}),
        .dout  (w_req_head),
        .full  (w_req_full),
        .empty (w_req_empty),
        .count (w_req_count)
    );

    // Ready reflects next-cycle fullness so a push never targets a full FIFO.
    assign w_req_cnt_nxt = UW'(w_req_count) + UW'(w_req_push) - UW'(w_issue);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= (w_req_cnt_nxt != UW'(DEPTH));
        end
    end

    // Every in-flight request owns a result slot: issue only while one is free.
    assign w_used      = UW'(r_inflight) + UW'(w_res_count);
    assign w_credit_ok = (w_used < UW'(DEPTH));

    assign w_issue = (r_state == IDLE) && !w_req_empty && !a_busy && w_credit_ok;

    // Issue FSM: one ivalid cycle, then a guard cycle while the adder's
    // registered busy comes up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_a_ivalid <= 1'b0;
            r_a_in1    <= '0;
            r_a_in2    <= '0;
        end else begin
            r_a_ivalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state    <= ISSUE;
                        r_a_ivalid <= 1'b1;
                        r_a_in1    <= w_req_head[QW-1:DWIDTH];
                        r_a_in2    <= w_req_head[DWIDTH-1:0];
                    end
                end
                ISSUE:   r_state <= GUARD;
                GUARD:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Returns are matched to in-flight requests by order; extras are dropped.
    assign w_ret_ok = a_ovalid && (r_inflight != '0);
    assign w_spur   = a_ovalid && (r_inflight == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_issue, w_ret_ok})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (w_spur) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result side.
    assign w_ret      = '{carry: a_carry, sum: a_sum};
    assign w_res_push = w_ret_ok && !w_res_full;
    assign w_res_pop  = !w_res_empty && m_ready;

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_res_push),
        .pop   (w_res_pop),
        .din   (w_ret),
        .dout  (w_res_head),
        .full  (w_res_full),
        .empty (w_res_empty),
        .count (w_res_count)
    );

    assign s_ready      = r_s_ready;
    assign a_in1        = r_a_in1;
    assign a_in2        = r_a_in2;
    assign a_ivalid     = r_a_ivalid;
    assign m_valid      = !w_res_empty;
    assign m_sum        = w_res_head;
    assign inflight     = r_inflight;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_adder_issuer.sv
// Directed bench for adder_issuer with a small behavioural adder model.
module tb_adder_issuer;

    localparam int MDL_LAT = 3;

    logic       clk;
    logic       rstn;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic [7:0] a_in1;
    logic [7:0] a_in2;
    logic       a_ivalid;
    logic       a_busy;
    logic [7:0] a_sum;
    logic       a_carry;
    logic       a_ovalid;
    logic       m_valid;
    logic       m_ready;
    logic [8:0] m_sum;
    logic [2:0] inflight;
    logic       err_spurious;

    // Adder model and manual overrides.
    logic       mdl_busy;
    logic       mdl_ovalid;
    logic [8:0] mdl_res;
    int         mdl_cnt;
    logic       tb_busy_force;
    logic       tb_manual;
    logic       tb_ovalid;
    logic [7:0] tb_sum;

    int n_cmp;
    int n_bad;
    int n_iv;
    int n_acc;
    int n_viol;

    logic [7:0] pend_a [$];
    logic [7:0] pend_b [$];
    logic [8:0] exp_q  [$];
    logic [8:0] got_q  [$];

    logic [7:0] tab_a [10] = '{8'hFF, 8'h01, 8'h7F, 8'h80, 8'h00, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'hFE};
    logic [7:0] tab_b [10] = '{8'h01, 8'hFF, 8'h01, 8'h80, 8'h00, 8'h55, 8'hAB, 8'h3D, 8'hC4, 8'hFF};

    adder_issuer #(
        .DWIDTH (8),
        .DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .a_in1        (a_in1),
        .a_in2        (a_in2),
        .a_ivalid     (a_ivalid),
        .a_busy       (a_busy),
        .a_sum        (a_sum),
        .a_carry      (a_carry),
        .a_ovalid     (a_ovalid),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sum        (m_sum),
        .inflight     (inflight),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    assign a_busy   = mdl_busy | tb_busy_force;
    assign a_ovalid = tb_manual ? tb_ovalid : mdl_ovalid;
    assign a_sum    = tb_manual ? tb_sum : mdl_res[7:0];
    assign a_carry  = tb_manual ? 1'b0 : mdl_res[8];

    // Busy rises the edge after ivalid; result returns MDL_LAT edges later.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdl_busy   <= 1'b0;
            mdl_ovalid <= 1'b0;
            mdl_cnt    <= 0;
            mdl_res    <= '0;
        end else begin
            mdl_ovalid <= 1'b0;
            if (mdl_busy) begin
                if (mdl_cnt == 1) begin
                    mdl_busy   <= 1'b0;
                    mdl_ovalid <= 1'b1;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end else if (a_ivalid) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= MDL_LAT;
                mdl_res  <= 9'(a_in1) + 9'(a_in2);
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the pending request, log handshakes about to happen, advance one cycle.
    task automatic step();
        s_valid = (pend_a.size() != 0);
        if (s_valid) begin
            s_a = pend_a[0];
            s_b = pend_b[0];
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(9'(s_a) + 9'(s_b));
            void'(pend_a.pop_front());
            void'(pend_b.pop_front());
            n_acc++;
        end
        if (m_valid && m_ready) got_q.push_back(m_sum);
        if (a_ivalid) n_iv++;
        if (a_ivalid && mdl_busy) n_viol++;
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, input bit rnd);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
    endtask

    task automatic add_req(input logic [7:0] a, input logic [7:0] b);
        pend_a.push_back(a);
        pend_b.push_back(b);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        pend_a.delete();
        pend_b.delete();
    endtask

    task automatic chk_results(input string tag, input int n);
        chk_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size() && i < exp_q.size())
                chk_eq($sformatf("%s_res%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_eq({tag, "_s_ready"},  32'(s_ready), 32'd0);
        chk_eq({tag, "_a_ivalid"}, 32'(a_ivalid), 32'd0);
        chk_eq({tag, "_a_in1"},    32'(a_in1), 32'd0);
        chk_eq({tag, "_a_in2"},    32'(a_in2), 32'd0);
        chk_eq({tag, "_m_valid"},  32'(m_valid), 32'd0);
        chk_eq({tag, "_m_sum"},    32'(m_sum), 32'd0);
        chk_eq({tag, "_inflight"}, 32'(inflight), 32'd0);
        chk_eq({tag, "_err"},      32'(err_spurious), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int iv0;
        int acc0;

        n_cmp = 0; n_bad = 0; n_iv = 0; n_acc = 0; n_viol = 0;
        clk = 1'b0; rstn = 1'b1;
        s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        tb_busy_force = 1'b0; tb_manual = 1'b0; tb_ovalid = 1'b0; tb_sum = '0;

        // Reset values.
        #1 rstn = 1'b0;
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_eq("rst_s_ready_up", 32'(s_ready), 32'd1);

        // Single add with carry out.
        clear_q();
        m_ready = 1'b1;
        iv0 = n_iv;
        add_req(8'hFF, 8'h01);
        run_until(1, 60, 1'b0);
        repeat (4) step();
        chk_eq("single_count", 32'(got_q.size()), 32'd1);
        chk_eq("single_sum", 32'(got_q[0]), 32'h100);
        chk_eq("single_ivalid_pulses", 32'(n_iv - iv0), 32'd1);
        chk_eq("single_in1_hold", 32'(a_in1), 32'hFF);
        chk_eq("single_in2_hold", 32'(a_in2), 32'h01);
        chk_eq("single_inflight", 32'(inflight), 32'd0);
        chk_eq("single_m_valid", 32'(m_valid), 32'd0);

        // Busy hold: nothing issues while busy, issue right after it drops.
        clear_q();
        tb_busy_force = 1'b1;
        iv0 = n_iv;
        add_req(8'h12, 8'h34);
        add_req(8'h80, 8'h80);
        repeat (20) step();
        chk_eq("busy_no_ivalid", 32'(n_iv - iv0), 32'd0);
        chk_eq("busy_inflight", 32'(inflight), 32'd0);
        tb_busy_force = 1'b0;
        step();
        chk_eq("busy_first_issue", 32'(a_ivalid), 32'd1);
        chk_eq("busy_first_in1", 32'(a_in1), 32'h12);
        chk_eq("busy_first_in2", 32'(a_in2), 32'h34);
        chk_eq("busy_inflight_issued", 32'(inflight), 32'd1);
        run_until(2, 100, 1'b0);
        chk_eq("busy_count", 32'(got_q.size()), 32'd2);
        chk_eq("busy_res0", 32'(got_q[0]), 32'h046);
        chk_eq("busy_res1", 32'(got_q[1]), 32'h100);

        // Backpressure: result space caps issues at DEPTH.
        clear_q();
        m_ready = 1'b0;
        iv0 = n_iv;
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) add_req(tab_a[i], tab_b[i]);
        repeat (80) step();
        chk_eq("bp_issues", 32'(n_iv - iv0), 32'd4);
        chk_eq("bp_accepted", 32'(n_acc - acc0), 32'd8);
        chk_eq("bp_s_ready", 32'(s_ready), 32'd0);
        chk_eq("bp_m_valid", 32'(m_valid), 32'd1);
        chk_eq("bp_head", 32'(m_sum), 32'h100);
        chk_eq("bp_inflight", 32'(inflight), 32'd0);
        m_ready = 1'b1;
        run_until(10, 400, 1'b0);
        chk_results("bp", 10);

        // Spurious return with nothing in flight.
        clear_q();
        tb_manual = 1'b1;
        tb_sum = 8'h55;
        tb_ovalid = 1'b1;
        step();
        tb_ovalid = 1'b0;
        step();
        chk_eq("spur_err", 32'(err_spurious), 32'd1);
        chk_eq("spur_m_valid", 32'(m_valid), 32'd0);
        chk_eq("spur_inflight", 32'(inflight), 32'd0);
        repeat (5) step();
        chk_eq("spur_err_sticky", 32'(err_spurious), 32'd1);
        tb_manual = 1'b0;

        // Reset with 3 queued and 1 in flight.
        clear_q();
        m_ready = 1'b1;
        add_req(8'h21, 8'h43);
        add_req(8'h01, 8'h02);
        add_req(8'h03, 8'h04);
        add_req(8'h05, 8'h06);
        repeat (4) step();
        chk_eq("mid_pre_inflight", 32'(inflight), 32'd1);
        chk_eq("mid_pre_m_valid", 32'(m_valid), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        clear_q();
        add_req(8'h10, 8'h20);
        run_until(1, 60, 1'b0);
        repeat (10) step();
        chk_eq("mid_count", 32'(got_q.size()), 32'd1);
        chk_eq("mid_first", 32'(got_q[0]), 32'h030);
        chk_eq("mid_err", 32'(err_spurious), 32'd0);

        // Streaming with random result backpressure.
        clear_q();
        for (int i = 0; i < 50; i++) add_req(8'(i * 37 + 11), 8'(i * 113 + 7));
        run_until(50, 3000, 1'b1);
        m_ready = 1'b1;
        repeat (3) step();
        chk_results("strm", 50);
        chk_eq("strm_ivalid_vs_busy", 32'(n_viol), 32'd0);
        chk_eq("strm_inflight", 32'(inflight), 32'd0);
        chk_eq("strm_m_valid", 32'(m_valid), 32'd0);
        chk_eq("strm_err", 32'(err_spurious), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
